// File: rtl/gf180mcu_fd_sc_mcu9t5v0__nor4_qual_2.sv
// Registered, glitch-qualified 4-input NOR with edge strobe and saturating rise counter.
// Optional build macro NOR4_QUAL_SYNC_EN adds a 2-flop synchronizer on A1..A4.
module gf180mcu_fd_sc_mcu9t5v0__nor4_qual_2 #(
   parameter int unsigned FILT_CYCLES = 4,
   parameter int unsigned EVT_W       = 8
) (
   input  logic             CLK,
   input  logic             RN,
   input  logic             A1,
   input  logic             A2,
   input  logic             A3,
   input  logic             A4,
   input  logic             CLR,
   output logic             ZN,
   output logic             ZN_EDGE,
   output logic [EVT_W-1:0] EVT_CNT
);

   localparam int unsigned FCW    = $clog2(FILT_CYCLES + 1);
   localparam logic [FCW:0] FILT_V = (FCW + 1)'(FILT_CYCLES);

   typedef enum logic [1:0] {
      ST_LO   = 2'b00,
      PEND_HI = 2'b01,
      ST_HI   = 2'b10,
      PEND_LO = 2'b11
   } state_t;

   state_t           r_state;
   logic [FCW-1:0]   r_fcnt;
   logic             w_raw;
   logic             w_hi;
   logic             w_diff;
   logic             w_fire;
   logic             w_bad;
   logic [FCW:0]     w_fcnt_inc;

`ifdef NOR4_QUAL_SYNC_EN
   logic [3:0] r_sync1;
   logic [3:0] r_sync2;
   logic [1:0] r_sv;

   // Synchronizer; r_sv holds raw low until real samples have crossed both flops
   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_sv    <= '0;
      end else begin
         r_sync1 <= {A4, A3, A2, A1};
         r_sync2 <= r_sync1;
         r_sv    <= {r_sv[0], 1'b1};
      end
   end

   assign w_raw = r_sv[1] & ~(|r_sync2);
`else
   assign w_raw = ~(A1 | A2 | A3 | A4);
`endif

   assign w_hi       = (r_state == ST_HI) || (r_state == PEND_LO);
   assign w_fcnt_inc = {1'b0, r_fcnt} + (FCW + 1)'(1);
   assign w_bad      = ({1'b0, r_fcnt} >= FILT_V);
   assign w_diff     = (w_raw != w_hi);
   assign w_fire     = w_diff && (w_fcnt_inc == FILT_V);

   // Qualification FSM, output registers and event counter
   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         r_state <= ST_LO;
         r_fcnt  <= '0;
         ZN      <= 1'b0;
         ZN_EDGE <= 1'b0;
         EVT_CNT <= '0;
      end else begin
         ZN_EDGE <= 1'b0;
         if (w_bad) begin
            // Out-of-range filter count cannot be trusted: restart low
            r_state <= ST_LO;
            r_fcnt  <= '0;
            ZN      <= 1'b0;
         end else if (!w_diff) begin
            r_state <= w_hi ? ST_HI : ST_LO;
            r_fcnt  <= '0;
            ZN      <= w_hi;
         end else if (w_fire) begin
            r_state <= w_hi ? ST_LO : ST_HI;
            r_fcnt  <= '0;
            ZN      <= ~w_hi;
            ZN_EDGE <= 1'b1;
         end else begin
            r_state <= w_hi ? PEND_LO : PEND_HI;
            r_fcnt  <= w_fcnt_inc[FCW-1:0];
            ZN      <= w_hi;
         end

         if (CLR) begin
            EVT_CNT <= '0;
         end else if (w_fire && !w_hi && !w_bad && (EVT_CNT != '1)) begin
            EVT_CNT <= EVT_CNT + EVT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__nor4_qual_2.sv
// Bench for the qualified NOR4: three parameter sets driven in parallel and compared
// against a run-length reference model, with directed scenarios followed by random holds.
module tb_gf180mcu_fd_sc_mcu9t5v0__nor4_qual_2;

`ifdef NOR4_QUAL_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   logic clk = 1'b0;
   logic rn  = 1'b0;
   logic a1 = 1'b0, a2 = 1'b0, a3 = 1'b0, a4 = 1'b0;
   logic clr = 1'b0;

   logic       zn0, ze0, zn1, ze1, zn2, ze2;
   logic [7:0] cnt0;
   logic [1:0] cnt1;
   logic [7:0] cnt2;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state per instance
   int filt  [3] = '{4, 2, 1};
   int evmax [3] = '{255, 3, 255};
   int m_zn  [3];
   int m_run [3];
   int m_cnt [3];
   int m_edge[3];
   int s1, s2;

   always #5 clk = ~clk;

   gf180mcu_fd_sc_mcu9t5v0__nor4_qual_2 #(.FILT_CYCLES(4), .EVT_W(8)) u_dut0 (
      .CLK(clk), .RN(rn), .A1(a1), .A2(a2), .A3(a3), .A4(a4), .CLR(clr),
      .ZN(zn0), .ZN_EDGE(ze0), .EVT_CNT(cnt0));

   gf180mcu_fd_sc_mcu9t5v0__nor4_qual_2 #(.FILT_CYCLES(2), .EVT_W(2)) u_dut1 (
      .CLK(clk), .RN(rn), .A1(a1), .A2(a2), .A3(a3), .A4(a4), .CLR(clr),
      .ZN(zn1), .ZN_EDGE(ze1), .EVT_CNT(cnt1));

   gf180mcu_fd_sc_mcu9t5v0__nor4_qual_2 #(.FILT_CYCLES(1), .EVT_W(8)) u_dut2 (
      .CLK(clk), .RN(rn), .A1(a1), .A2(a2), .A3(a3), .A4(a4), .CLR(clr),
      .ZN(zn2), .ZN_EDGE(ze2), .EVT_CNT(cnt2));

   task automatic chk(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_zn[i] = 0; m_run[i] = 0; m_cnt[i] = 0; m_edge[i] = 0;
      end
      s1 = 0;
      s2 = 0;
   endtask

   // ZN flips once the raw value has differed from it on filt consecutive edges
   task automatic model_step(input int raw_in, input int clr_in);
      int raw;
      if (LAT == 2) begin
         raw = s2;
         s2  = s1;
         s1  = raw_in;
      end else begin
         raw = raw_in;
      end
      for (int i = 0; i < 3; i++) begin
         m_edge[i] = 0;
         if (raw != m_zn[i]) m_run[i]++;
         else                m_run[i] = 0;
         if (m_run[i] == filt[i]) begin
            m_zn[i]   = 1 - m_zn[i];
            m_run[i]  = 0;
            m_edge[i] = 1;
            if (m_zn[i] == 1 && m_cnt[i] < evmax[i]) m_cnt[i]++;
         end
         if (clr_in != 0) m_cnt[i] = 0;
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, "_zn0"}, int'(zn0), m_zn[0]);
      chk({tag, "_ze0"}, int'(ze0), m_edge[0]);
      chk({tag, "_cnt0"}, int'(cnt0), m_cnt[0]);
      chk({tag, "_zn1"}, int'(zn1), m_zn[1]);
      chk({tag, "_ze1"}, int'(ze1), m_edge[1]);
      chk({tag, "_cnt1"}, int'(cnt1), m_cnt[1]);
      chk({tag, "_zn2"}, int'(zn2), m_zn[2]);
      chk({tag, "_ze2"}, int'(ze2), m_edge[2]);
      chk({tag, "_cnt2"}, int'(cnt2), m_cnt[2]);
   endtask

   task automatic tick(input logic [3:0] a, input logic c, input string tag);
      {a4, a3, a2, a1} = a;
      clr = c;
      @(posedge clk);
      model_step((a == 4'h0) ? 1 : 0, int'(c));
      #1;
      check_all(tag);
   endtask

   // Async reset applied between edges; outputs must clear without a clock
   task automatic do_reset(input string tag);
      rn = 1'b0;
      #1;
      model_reset();
      chk({tag, "_rst_zn"}, int'(zn0), 0);
      chk({tag, "_rst_ze"}, int'(ze0), 0);
      chk({tag, "_rst_cnt"}, int'(cnt0), 0);
      check_all({tag, "_rst"});
      #1;
      rn = 1'b1;
   endtask

   // Held all-zero inputs: dut0 rises on exactly the (4+LAT)-th edge
   task automatic rise_from_reset(input string tag, input int exp_cnt);
      for (int i = 0; i < 3 + LAT; i++) begin
         tick(4'h0, 1'b0, tag);
         chk({tag, "_lo"}, int'(zn0), 0);
      end
      tick(4'h0, 1'b0, tag);
      chk({tag, "_rise"}, int'(zn0), 1);
      chk({tag, "_edge"}, int'(ze0), 1);
      chk({tag, "_cnt"}, int'(cnt0), exp_cnt);
      tick(4'h0, 1'b0, tag);
      chk({tag, "_edge_off"}, int'(ze0), 0);
   endtask

   initial begin
      logic [3:0] a;
      int         len;
      model_reset();
      #2;
      do_reset("init");

      rise_from_reset("t1", 1);

      // Short A2 glitch must not disturb a settled ZN=1
      for (int i = 0; i < 3; i++) begin
         tick(4'b0010, 1'b0, "t2");
         chk("t2_hold", int'(zn0), 1);
      end
      for (int i = 0; i < 4 + LAT; i++) begin
         tick(4'h0, 1'b0, "t2");
         chk("t2_hold", int'(zn0), 1);
         chk("t2_noedge", int'(ze0), 0);
      end

      for (int i = 0; i < 3 + LAT; i++) begin
         tick(4'b0100, 1'b0, "t3");
         chk("t3_hold", int'(zn0), 1);
      end
      tick(4'b0100, 1'b0, "t3");
      chk("t3_fall", int'(zn0), 0);
      chk("t3_edge", int'(ze0), 1);
      chk("t3_cnt", int'(cnt0), 1);

      // Saturation on the 2-bit counter, then CLR beating a coincident rise
      tick(4'hF, 1'b1, "t4");
      chk("t4_clr", int'(cnt1), 0);
      for (int k = 1; k <= 5; k++) begin
         for (int i = 0; i < 6; i++) tick(4'h0, 1'b0, "t4");
         chk("t4_sat", int'(cnt1), (k < 3) ? k : 3);
         for (int i = 0; i < 6; i++) tick(4'hF, 1'b0, "t4");
      end
      for (int i = 0; i < 6; i++) tick(4'h0, 1'b1, "t4");
      chk("t4_clr_cnt", int'(cnt1), 0);
      chk("t4_clr_zn", int'(zn1), 1);

      // Reset in the middle of a pending rise discards the partial count
      for (int i = 0; i < 6; i++) tick(4'h1, 1'b0, "t5");
      for (int i = 0; i < 2 + LAT; i++) tick(4'h0, 1'b0, "t5");
      do_reset("t5");
      rise_from_reset("t5", 1);

      // Random held patterns with occasional clears and resets
      for (int it = 0; it < 400; it++) begin
         a   = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
         len = $urandom_range(1, 7);
         for (int j = 0; j < len; j++) begin
            tick(a, ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0, "rnd");
         end
         if ($urandom_range(0, 99) == 0) do_reset("rnd");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
